// File: rtl/roic_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// roic_pkg : shared state encoding, default durations and width helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package roic_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RST    = 4'd1,
    S_INTG   = 4'd2,
    S_PHASEC = 4'd3,
    S_DELAY  = 4'd4,
    S_SMPL   = 4'd5,
    S_CNVRT  = 4'd6,
    S_TRNSFR = 4'd7,
    S_STOP   = 4'd8
  } state_e;

  localparam int DEF_NROWS      = 3;
  localparam int DEF_NLANES     = 2;
  localparam int DEF_ADC_BITS   = 10;
  localparam int DEF_CNV_CLKS   = 9;
  localparam int DEF_RST_CYC    = 64;
  localparam int DEF_INTG_CYC   = 1024;
  localparam int DEF_PHC_CYC    = 8;
  localparam int DEF_DLY_CYC    = 8;
  localparam int DEF_SMPL_CYC   = 32;
  localparam int DEF_STOP_CYC   = 6;
  localparam int DEF_CAL_FRAMES = 64;

  function automatic int word_width(input int nlanes, input int adc_bits);
    return nlanes * adc_bits;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_deser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_deser : per-lane MSB-first shift registers for the column ADC serial data
// Rev 1.0
// ----------------------------------------------------------------------------
module adc_deser
  import roic_pkg::*;
#(
  parameter int NLANES   = DEF_NLANES,
  parameter int ADC_BITS = DEF_ADC_BITS
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      clr_i,
  input  logic                                      shift_en_i,
  input  logic [NLANES-1:0]                         sdata_i,
  output logic [word_width(NLANES, ADC_BITS)-1:0]   word_o
);

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    logic [ADC_BITS-1:0] lane_q;

    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        lane_q <= '0;
      end else if (shift_en_i) begin
        lane_q <= {lane_q[ADC_BITS-2:0], sdata_i[l]};
      end
    end

    assign word_o[l*ADC_BITS +: ADC_BITS] = lane_q;
  end

endmodule
`default_nettype wire

// File: rtl/roic_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// roic_frame_sequencer : pixel phase, row select and column ADC frame sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
module roic_frame_sequencer
  import roic_pkg::*;
#(
  parameter int NROWS      = DEF_NROWS,
  parameter int NLANES     = DEF_NLANES,
  parameter int ADC_BITS   = DEF_ADC_BITS,
  parameter int CNV_CLKS   = DEF_CNV_CLKS,
  parameter int RST_CYC    = DEF_RST_CYC,
  parameter int INTG_CYC   = DEF_INTG_CYC,
  parameter int PHC_CYC    = DEF_PHC_CYC,
  parameter int DLY_CYC    = DEF_DLY_CYC,
  parameter int SMPL_CYC   = DEF_SMPL_CYC,
  parameter int STOP_CYC   = DEF_STOP_CYC,
  parameter int CAL_FRAMES = DEF_CAL_FRAMES
) (
  input  logic                                      OSC_in,
  input  logic                                      Rst_in,
  input  logic                                      Start,
  input  logic                                      Continuous,
  output logic                                      Busy,
  output logic                                      PhaseA,
  output logic                                      PhaseC,
  output logic                                      PixRst,
  output logic [NROWS-1:0]                          RowSel,
  output logic                                      ADRst,
  output logic                                      ADMode,
  output logic                                      ADMode1,
  output logic                                      ADClk,
  input  logic [NLANES-1:0]                         ADSout,
  output logic [word_width(NLANES, ADC_BITS)-1:0]   Word,
  output logic                                      WordValid,
  output logic [bits_for(NROWS)-1:0]                RowIdx,
  output logic                                      FrameDone,
  output logic                                      CalReq
);

  localparam int MAXD = imax(imax(imax(RST_CYC, INTG_CYC), imax(PHC_CYC, DLY_CYC)),
                             imax(imax(SMPL_CYC, STOP_CYC), imax(2*CNV_CLKS, 2*ADC_BITS)));
  localparam int CW   = bits_for(MAXD);
  localparam int RW   = bits_for(NROWS);
  localparam int FCW  = bits_for(CAL_FRAMES);

  localparam logic [CW-1:0]  L_RST    = CW'(RST_CYC - 1);
  localparam logic [CW-1:0]  L_INTG   = CW'(INTG_CYC - 1);
  localparam logic [CW-1:0]  L_PHC    = CW'(PHC_CYC - 1);
  localparam logic [CW-1:0]  L_DLY    = CW'(DLY_CYC - 1);
  localparam logic [CW-1:0]  L_SMPL   = CW'(SMPL_CYC - 1);
  localparam logic [CW-1:0]  L_CNV    = CW'(2*CNV_CLKS - 1);
  localparam logic [CW-1:0]  L_TRN    = CW'(2*ADC_BITS - 1);
  localparam logic [CW-1:0]  L_STOP   = CW'(STOP_CYC - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(NROWS - 1);
  localparam logic [FCW-1:0] FC_LAST  = FCW'((CAL_FRAMES > 0) ? CAL_FRAMES - 1 : 0);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic [NROWS-1:0] rowsel_q, rowsel_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic             shift_en, clr;

  always_ff @(posedge OSC_in) begin
    if (Rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      rowsel_q <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      rowsel_q <= rowsel_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    row_d     = row_q;
    rowsel_d  = rowsel_q;
    fcnt_d    = fcnt_q;
    PhaseA    = 1'b0;
    PhaseC    = 1'b0;
    PixRst    = 1'b0;
    ADRst     = 1'b0;
    ADMode    = 1'b0;
    ADMode1   = 1'b0;
    ADClk     = 1'b0;
    WordValid = 1'b0;
    FrameDone = 1'b0;
    CalReq    = 1'b0;
    shift_en  = 1'b0;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        PhaseA = 1'b1;
        PixRst = 1'b1;
        cnt_d  = '0;
        if (Start) begin
          state_d = S_RST;
          row_d   = '0;
        end
      end
      S_RST: begin
        PhaseA = 1'b1;
        if (cnt_q == L_RST) state_d = S_INTG;
      end
      S_INTG: begin
        if (cnt_q == L_INTG) state_d = S_PHASEC;
      end
      S_PHASEC: begin
        PhaseC = 1'b1;
        if (cnt_q == L_PHC) state_d = S_DELAY;
      end
      S_DELAY: begin
        if (cnt_q == L_DLY) begin
          state_d  = S_SMPL;
          rowsel_d = NROWS'(1) << row_q;
        end
      end
      S_SMPL: begin
        ADMode = 1'b1;
        clr    = 1'b1;
        if (cnt_q == L_SMPL) state_d = S_CNVRT;
      end
      S_CNVRT: begin
        ADRst  = 1'b1;
        ADMode = 1'b1;
        ADClk  = cnt_q[0];
        if (cnt_q == L_CNV) state_d = S_TRNSFR;
      end
      S_TRNSFR: begin
        // Data is taken on the ADClk-high cycles only, one bit per period.
        ADRst    = 1'b1;
        ADMode1  = 1'b1;
        ADClk    = cnt_q[0];
        shift_en = cnt_q[0];
        if (cnt_q == L_TRN) state_d = S_STOP;
      end
      S_STOP: begin
        WordValid = (cnt_q == '0);
        if (cnt_q == L_STOP) begin
          rowsel_d = '0;
          if (row_q != ROW_LAST) begin
            row_d   = row_q + RW'(1);
            state_d = S_DELAY;
          end else begin
            FrameDone = 1'b1;
            row_d     = '0;
            if (CAL_FRAMES != 0) begin
              if (fcnt_q == FC_LAST) begin
                CalReq = 1'b1;
                fcnt_d = '0;
              end else begin
                fcnt_d = fcnt_q + FCW'(1);
              end
            end
            state_d = Continuous ? S_RST : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign Busy   = (state_q != S_IDLE);
  assign RowSel = rowsel_q;
  assign RowIdx = row_q;

  adc_deser #(
    .NLANES   (NLANES),
    .ADC_BITS (ADC_BITS)
  ) u_deser (
    .clk_i      (OSC_in),
    .rst_i      (Rst_in),
    .clr_i      (clr),
    .shift_en_i (shift_en),
    .sdata_i    (ADSout),
    .word_o     (Word)
  );

endmodule
`default_nettype wire
